wb_commit: RTL

Writeback/commit stage of the in-order pipeline, consuming the MM2→WB pipeline register outputs. Formats load data (byte lane select, sign/zero extension), commits register-file writes, and performs masked CSR read-modify-write through a 3-state FSM that back-pressures the pipeline. Also drives the difftest debug trace and a retired-instruction counter.

---
 rtl/wb_commit.sv | 238 +++++++++++++++++++++++
 1 files changed

// File: rtl/wb_commit.sv
// wb_commit: writeback/commit stage.
// Formats load data, commits register-file writes, and runs a masked CSR
// read-modify-write through a small FSM that holds off the pipeline while
// the CSR access is in flight. Also drives the difftest trace and a
// retired-instruction counter. Every output is a register.
//
// Handshake: an instruction is taken on a rising edge where
// in_valid & in_ready are both high. in_ready is high only while the FSM is
// IDLE. Inputs offered while in_ready is low are ignored, not queued.
module wb_commit #(
  parameter int RETIRE_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [31:0]         in_pc,
  input  logic [3:0]          in_op_type,
  input  logic [7:0]          in_op,
  input  logic [31:0]         in_exe_out,
  input  logic [31:0]         in_rdata,
  input  logic [1:0]          in_mm_access_sz,
  input  logic [4:0]          in_reg_d,
  input  logic                in_reg_d_wen,
  input  logic [13:0]         in_csr_addr,
  input  logic [31:0]         in_csr_wdata,
  input  logic [31:0]         in_csr_wmask,
  output logic                csr_re,
  output logic [13:0]         csr_raddr,
  input  logic [31:0]         csr_rdata,
  output logic                csr_we,
  output logic [13:0]         csr_waddr,
  output logic [31:0]         csr_wdata,
  output logic                rf_we,
  output logic [4:0]          rf_waddr,
  output logic [31:0]         rf_wdata,
  output logic [31:0]         debug_wb_pc,
  output logic [3:0]          debug_wb_rf_we,
  output logic [4:0]          debug_wb_rf_wnum,
  output logic [31:0]         debug_wb_rf_wdata,
  output logic [RETIRE_W-1:0] retire_cnt,
  output logic [1:0]          debug_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CSR_RD = 2'd1,
    CSR_WR = 2'd2
  } state_t;

  localparam logic [3:0] OP_LOAD = 4'd1;
  localparam logic [3:0] OP_CSR  = 4'd4;

  state_t state;
  state_t state_nx;

  logic        accept;
  logic        in_is_csr;
  logic        in_is_load;

  // CSR instruction held for the duration of the read-modify-write
  logic [13:0] lat_csr_addr;
  logic [31:0] lat_csr_wdata;
  logic [31:0] lat_csr_wmask;
  logic [31:0] lat_pc;
  logic [4:0]  lat_reg_d;
  logic        lat_reg_d_wen;

  // Next-cycle commit information produced by the FSM logic
  logic        commit;
  logic [4:0]  commit_reg_d;
  logic        commit_wen;
  logic [31:0] commit_wdata;
  logic [31:0] commit_pc;
  logic        csr_re_nx;
  logic        csr_we_nx;
  logic [31:0] csr_merge;

  // Load formatting intermediates
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_data;

  // op[7:1] carry nothing this stage needs
  logic        unused_op_bits;
  assign unused_op_bits = ^in_op[7:1];

  assign accept     = in_valid & in_ready;
  assign in_is_csr  = (in_op_type == OP_CSR);
  assign in_is_load = (in_op_type == OP_LOAD);

  // Load formatting: select the addressed lane, then sign- or zero-extend
  always_comb begin
    byte_sel  = 8'h00;
    half_sel  = 16'h0000;
    load_data = 32'h0000_0000;
    case (in_exe_out[1:0])
      2'd0:    byte_sel = in_rdata[7:0];
      2'd1:    byte_sel = in_rdata[15:8];
      2'd2:    byte_sel = in_rdata[23:16];
      default: byte_sel = in_rdata[31:24];
    endcase
    // Halfword loads are naturally aligned, so only address bit 1 matters
    half_sel = in_exe_out[1] ? in_rdata[31:16] : in_rdata[15:0];
    case (in_mm_access_sz)
      2'd0:    load_data = in_op[0] ? {24'h000000, byte_sel}
                                    : {{24{byte_sel[7]}}, byte_sel};
      2'd1:    load_data = in_op[0] ? {16'h0000, half_sel}
                                    : {{16{half_sel[15]}}, half_sel};
      default: load_data = in_rdata;
    endcase
  end

  // Masked merge of the old CSR value (on csr_rdata in the second CSR_RD cycle)
  assign csr_merge = (csr_rdata & ~lat_csr_wmask) | (lat_csr_wdata & lat_csr_wmask);

  // Next-state and next-output logic for the commit FSM
  always_comb begin
    state_nx     = state;
    commit       = 1'b0;
    commit_reg_d = in_reg_d;
    commit_wen   = in_reg_d_wen;
    commit_wdata = in_exe_out;
    commit_pc    = in_pc;
    csr_re_nx    = 1'b0;
    csr_we_nx    = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (in_is_csr) begin
            // Issue the CSR read; the commit happens once the old value is back
            state_nx  = CSR_RD;
            csr_re_nx = 1'b1;
          end else begin
            commit       = 1'b1;
            commit_wdata = in_is_load ? load_data : in_exe_out;
          end
        end
      end
      CSR_RD: begin
        // First CSR_RD cycle has csr_re high; read data is valid in the next one
        if (!csr_re) begin
          state_nx     = CSR_WR;
          commit       = 1'b1;
          csr_we_nx    = (lat_csr_wmask != 32'h0000_0000);
          commit_reg_d = lat_reg_d;
          commit_wen   = lat_reg_d_wen;
          commit_wdata = csr_rdata;
          commit_pc    = lat_pc;
        end
      end
      CSR_WR: begin
        // Write strobes are visible in this cycle; pipeline is released next
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Capture a CSR instruction when it is accepted
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lat_csr_addr  <= 14'h0000;
      lat_csr_wdata <= 32'h0000_0000;
      lat_csr_wmask <= 32'h0000_0000;
      lat_pc        <= 32'h0000_0000;
      lat_reg_d     <= 5'd0;
      lat_reg_d_wen <= 1'b0;
    end else if (state == IDLE && accept && in_is_csr) begin
      lat_csr_addr  <= in_csr_addr;
      lat_csr_wdata <= in_csr_wdata;
      lat_csr_wmask <= in_csr_wmask;
      lat_pc        <= in_pc;
      lat_reg_d     <= in_reg_d;
      lat_reg_d_wen <= in_reg_d_wen;
    end
  end

  // Handshake and CSR port registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      in_ready  <= 1'b1;
      csr_re    <= 1'b0;
      csr_raddr <= 14'h0000;
      csr_we    <= 1'b0;
      csr_waddr <= 14'h0000;
      csr_wdata <= 32'h0000_0000;
    end else begin
      in_ready <= (state_nx == IDLE);
      csr_re   <= csr_re_nx;
      csr_we   <= csr_we_nx;
      if (csr_re_nx) begin
        csr_raddr <= in_csr_addr;
      end
      if (csr_we_nx) begin
        csr_waddr <= lat_csr_addr;
        csr_wdata <= csr_merge;
      end
    end
  end

  // Register-file write port, trace PC and retire counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rf_we       <= 1'b0;
      rf_waddr    <= 5'd0;
      rf_wdata    <= 32'h0000_0000;
      debug_wb_pc <= 32'h0000_0000;
      retire_cnt  <= '0;
    end else begin
      // x0 is hardwired to zero, so a write to it is dropped
      rf_we <= commit & commit_wen & (commit_reg_d != 5'd0);
      if (commit) begin
        rf_waddr    <= commit_reg_d;
        rf_wdata    <= commit_wdata;
        debug_wb_pc <= commit_pc;
        retire_cnt  <= retire_cnt + RETIRE_W'(1);
      end
    end
  end

  assign debug_wb_rf_we    = {4{rf_we}};
  assign debug_wb_rf_wnum  = rf_waddr;
  assign debug_wb_rf_wdata = rf_wdata;
  assign debug_state       = state;

endmodule
